// File: rtl/riscv_inst_pack.sv
// Instruction packer: assembles R/I/U/J field bundles into 32-bit words and queues them in a small FIFO.
// Optional hazard padding (NOP words after flagged instructions) is enabled by defining RISCV_PACK_NOP_PAD_EN.
module riscv_inst_pack #(
    parameter int unsigned NOP_PAD  = 2,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_val,
    output logic        o_in_rdy,
    input  logic [1:0]  i_in_fmt,
    input  logic [6:0]  i_in_opcode,
    input  logic [4:0]  i_in_ra,
    input  logic [4:0]  i_in_rb,
    input  logic [4:0]  i_in_rc,
    input  logic [9:0]  i_in_funct,
    input  logic [11:0] i_in_imm,
    input  logic [19:0] i_in_bigimm,
    input  logic [26:0] i_in_target,
    input  logic        i_in_pad,
    output logic        o_out_val,
    input  logic        i_out_rdy,
    output logic [31:0] o_out_inst,
    output logic        o_out_is_nop
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PAD  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     w_packed;
    logic [31:0]     w_wdata;
    logic            w_full;
    logic            w_accept;
    logic            w_pad_push;
    logic            w_push;
    logic            w_pop;
    logic            w_out_val;

`ifdef RISCV_PACK_NOP_PAD_EN
    logic [2:0]      r_pad_cnt;
    logic [2:0]      w_pad_cnt_nxt;
    logic            r_mem_nop [DEPTH];
`else
    logic            w_unused_pad;
    assign w_unused_pad = i_in_pad;
`endif

    always_comb begin
        w_packed = '0;
        case (i_in_fmt)
            2'd0: w_packed = {i_in_opcode, i_in_ra, i_in_rb, i_in_funct, i_in_rc};
            2'd1: w_packed = {i_in_opcode, i_in_ra, i_in_rb, i_in_funct[2:0], i_in_imm};
            2'd2: w_packed = {i_in_opcode, i_in_ra, i_in_bigimm};
            2'd3: w_packed = {i_in_opcode[6:2], i_in_target};
        endcase
    end

    // Readiness is taken from the registered count only, so a same-cycle pop never opens a slot.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_out_val = (r_count != '0);
    assign w_pop     = w_out_val && i_out_rdy;
    assign w_push    = w_accept || w_pad_push;
    assign w_wdata   = w_pad_push ? NOP_INST : w_packed;

    always_comb begin
        w_state_nxt = r_state;
        o_in_rdy    = 1'b0;
        w_accept    = 1'b0;
        w_pad_push  = 1'b0;
`ifdef RISCV_PACK_NOP_PAD_EN
        w_pad_cnt_nxt = r_pad_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                o_in_rdy = !w_full;
                w_accept = i_in_val && !w_full;
`ifdef RISCV_PACK_NOP_PAD_EN
                if (w_accept && i_in_pad) begin
                    w_state_nxt   = S_PAD;
                    w_pad_cnt_nxt = 3'(NOP_PAD);
                end
`endif
            end
            S_PAD: begin
`ifdef RISCV_PACK_NOP_PAD_EN
                if (!w_full) begin
                    w_pad_push    = 1'b1;
                    w_pad_cnt_nxt = r_pad_cnt - 3'd1;
                    if (r_pad_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
`ifdef RISCV_PACK_NOP_PAD_EN
            r_pad_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
`ifdef RISCV_PACK_NOP_PAD_EN
            r_pad_cnt <= w_pad_cnt_nxt;
`endif
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wdata;
`ifdef RISCV_PACK_NOP_PAD_EN
            r_mem_nop[r_wr_ptr] <= w_pad_push;
`endif
        end
    end

    assign o_out_val  = w_out_val;
    assign o_out_inst = w_out_val ? r_mem[r_rd_ptr] : 32'h0;
`ifdef RISCV_PACK_NOP_PAD_EN
    assign o_out_is_nop = w_out_val && r_mem_nop[r_rd_ptr];
`else
    assign o_out_is_nop = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_inst_pack.sv
// Self-checking bench for riscv_inst_pack: queue-based reference model plus directed vectors.
// Adapts its padding expectations to whether RISCV_PACK_NOP_PAD_EN is defined.
module tb_riscv_inst_pack;
    localparam int          NOP_PAD = 2;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] NOP_W   = 32'h0000_0013;
`ifdef RISCV_PACK_NOP_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        clk;
    logic        i_reset;
    logic        i_in_val;
    logic        o_in_rdy;
    logic [1:0]  i_in_fmt;
    logic [6:0]  i_in_opcode;
    logic [4:0]  i_in_ra;
    logic [4:0]  i_in_rb;
    logic [4:0]  i_in_rc;
    logic [9:0]  i_in_funct;
    logic [11:0] i_in_imm;
    logic [19:0] i_in_bigimm;
    logic [26:0] i_in_target;
    logic        i_in_pad;
    logic        o_out_val;
    logic        i_out_rdy;
    logic [31:0] o_out_inst;
    logic        o_out_is_nop;

    riscv_inst_pack #(.NOP_PAD(NOP_PAD), .DEPTH(DEPTH), .NOP_INST(NOP_W)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_in_val(i_in_val), .o_in_rdy(o_in_rdy),
        .i_in_fmt(i_in_fmt), .i_in_opcode(i_in_opcode), .i_in_ra(i_in_ra), .i_in_rb(i_in_rb),
        .i_in_rc(i_in_rc), .i_in_funct(i_in_funct), .i_in_imm(i_in_imm),
        .i_in_bigimm(i_in_bigimm), .i_in_target(i_in_target), .i_in_pad(i_in_pad),
        .o_out_val(o_out_val), .i_out_rdy(i_out_rdy), .o_out_inst(o_out_inst),
        .o_out_is_nop(o_out_is_nop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pack(input logic [1:0] f, input logic [6:0] op,
                                           input logic [4:0] ra, input logic [4:0] rb,
                                           input logic [4:0] rc, input logic [9:0] fn,
                                           input logic [11:0] im, input logic [19:0] bi,
                                           input logic [26:0] tg);
        logic [31:0] w;
        w = 32'(op) << 25;
        case (f)
            2'd0: w = w | (32'(ra) << 20) | (32'(rb) << 15) | (32'(fn) << 5) | 32'(rc);
            2'd1: w = w | (32'(ra) << 20) | (32'(rb) << 15) | ((32'(fn) & 32'h7) << 12) | 32'(im);
            2'd2: w = w | (32'(ra) << 20) | 32'(bi);
            default: w = ((32'(op) >> 2) << 27) | 32'(tg);
        endcase
        return w;
    endfunction

    typedef struct packed {
        logic        nop;
        logic [31:0] inst;
    } ent_t;

    ent_t mq[$];
    int   m_pad_left  = 0;
    int   m_data_pops = 0;
    bit   chk_en      = 1'b0;

    // Outputs are compared on the falling edge; the model then advances using the inputs the next rising edge will see.
    always @(negedge clk) begin : model
        ent_t h;
        logic m_rdy;
        bit   acc;
        bit   pop;
        bit   pp;
        m_rdy = (m_pad_left == 0) && (mq.size() < DEPTH);
        h = (mq.size() != 0) ? mq[0] : '0;
        if (chk_en) begin
            check("out_val", 32'(o_out_val), 32'(mq.size() != 0));
            check("out_inst", o_out_inst, h.inst);
            check("out_is_nop", 32'(o_out_is_nop), 32'(h.nop));
            check("in_rdy", 32'(o_in_rdy), 32'(m_rdy));
        end
        if (i_reset) begin
            mq.delete();
            m_pad_left = 0;
        end else begin
            acc = i_in_val && m_rdy;
            pp  = (m_pad_left > 0) && (mq.size() < DEPTH);
            pop = (mq.size() != 0) && i_out_rdy;
            if (pop) begin
                if (!mq[0].nop) m_data_pops++;
                void'(mq.pop_front());
            end
            if (acc) begin
                mq.push_back({1'b0, m_pack(i_in_fmt, i_in_opcode, i_in_ra, i_in_rb, i_in_rc,
                                           i_in_funct, i_in_imm, i_in_bigimm, i_in_target)});
                if (PAD_ON && i_in_pad) m_pad_left = NOP_PAD;
            end
            if (pp) begin
                mq.push_back({1'b1, NOP_W});
                m_pad_left--;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge on which the bundle was accepted.
    task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] ra,
                        input logic [4:0] rb, input logic [4:0] rc, input logic [9:0] fn,
                        input logic [11:0] im, input logic [19:0] bi, input logic [26:0] tg,
                        input logic pd);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        i_in_val = 1'b1; i_in_fmt = f; i_in_opcode = op; i_in_ra = ra; i_in_rb = rb;
        i_in_rc = rc; i_in_funct = fn; i_in_imm = im; i_in_bigimm = bi; i_in_target = tg;
        i_in_pad = pd;
        while (!done && n < 50) begin
            @(negedge clk);
            if (o_in_rdy) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check("send_accept", 32'(done), 32'd1);
        i_in_val = 1'b0;
        i_in_pad = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_out_rdy = 1'b1;
        while ((mq.size() != 0 || m_pad_left != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_low;
        int nops;
        int pops0;
        i_reset = 1'b1; i_in_val = 1'b0; i_in_fmt = '0; i_in_opcode = '0; i_in_ra = '0;
        i_in_rb = '0; i_in_rc = '0; i_in_funct = '0; i_in_imm = '0; i_in_bigimm = '0;
        i_in_target = '0; i_in_pad = 1'b0; i_out_rdy = 1'b0;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_out_val", 32'(o_out_val), 32'd0);
        check("rst_out_inst", o_out_inst, 32'h0);
        check("rst_is_nop", 32'(o_out_is_nop), 32'd0);
        check("rst_in_rdy", 32'(o_in_rdy), 32'd1);

        // Single bundles of each format; unused fields carry junk that must be ignored.
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
        send(2'd0, 7'h33, 5'd1, 5'd2, 5'd3, 10'h000, 12'hABC, 20'h55555, 27'h7FFFFFF, 1'b0);
        @(negedge clk);
        check("R_word", o_out_inst, 32'h6611_0003);
        check("R_is_nop", 32'(o_out_is_nop), 32'd0);
        @(posedge clk); #1;
        send(2'd1, 7'h13, 5'd5, 5'd0, 5'd31, 10'h3F8, 12'hFFF, 20'hFFFFF, 27'h1234567, 1'b0);
        @(negedge clk);
        check("I_word", o_out_inst, 32'h2650_0FFF);
        @(posedge clk); #1;
        send(2'd2, 7'h37, 5'd7, 5'd31, 5'd9, 10'h3FF, 12'h123, 20'hABCDE, 27'h5A5A5A5, 1'b0);
        @(negedge clk);
        check("U_word", o_out_inst, 32'h6E7A_BCDE);
        @(posedge clk); #1;
        send(2'd3, 7'h6F, 5'd17, 5'd18, 5'd19, 10'h2AA, 12'h777, 20'h12345, 27'h0000010, 1'b0);
        @(negedge clk);
        check("J_word", o_out_inst, 32'hD800_0010);

        // Padding request
        @(posedge clk); #1;
        send(2'd0, 7'h33, 5'd1, 5'd2, 5'd3, 10'h000, 12'h0, 20'h0, 27'h0, 1'b1);
        rdy_low = 0;
        nops = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) check("pad_head_inst", o_out_inst, 32'h6611_0003);
            if (!o_in_rdy) rdy_low++;
            if (o_out_val && o_out_is_nop) nops++;
        end
        check("pad_rdy_low", 32'(rdy_low), PAD_ON ? 32'd2 : 32'd0);
        check("pad_nops", 32'(nops), PAD_ON ? 32'd2 : 32'd0);

        // Full FIFO with backpressure
        @(posedge clk); #1;
        i_out_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(2'd2, 7'h37, 5'(k), 5'd0, 5'd0, 10'h0, 12'h0, 20'h01000 + 20'(k), 27'h0, 1'b0);
        end
        @(negedge clk);
        check("full_in_rdy", 32'(o_in_rdy), 32'd0);
        @(posedge clk); #1;
        i_in_val = 1'b1; i_in_fmt = 2'd2; i_in_opcode = 7'h37; i_in_ra = 5'd4;
        i_in_bigimm = 20'h01004;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_head_hold", o_out_inst, 32'h6E00_1000);
            check("full_no_accept", 32'(o_in_rdy), 32'd0);
            @(posedge clk); #1;
        end
        i_out_rdy = 1'b1;
        @(posedge clk); #1;
        i_out_rdy = 1'b0;
        @(negedge clk);
        check("pop_in_rdy", 32'(o_in_rdy), 32'd1);
        check("pop_head", o_out_inst, 32'h6E10_1001);
        @(posedge clk); #1;
        i_in_val = 1'b0;
        drain();

        // Pointer wrap with toggling consumer
        pops0 = m_data_pops;
        i_out_rdy = 1'b0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(2'(k % 4), 7'(k * 13 + 5), 5'(k), 5'(k + 3), 5'(31 - k), 10'(k * 37),
                         12'(k * 291), 20'(k * 4099), 27'(k * 65537), 1'b0);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk); #1;
                    i_out_rdy = ~i_out_rdy;
                end
            end
        join
        drain();
        check("wrap_count", 32'(m_data_pops - pops0), 32'd10);

        // Reset while padding with two entries buffered
        @(posedge clk); #1;
        i_out_rdy = 1'b0;
        send(2'd1, 7'h13, 5'd5, 5'd0, 5'd0, 10'h0, 12'h001, 20'h0, 27'h0, 1'b0);
        send(2'd0, 7'h33, 5'd1, 5'd2, 5'd3, 10'h0, 12'h0, 20'h0, 27'h0, 1'b1);
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("mp_out_val", 32'(o_out_val), 32'd0);
        check("mp_out_inst", o_out_inst, 32'h0);
        check("mp_in_rdy", 32'(o_in_rdy), 32'd1);
        @(posedge clk); #1;
        i_out_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mp_no_residual", 32'(o_out_val), 32'd0);
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
